// File: rtl/adc_sample_packer.sv
// Packs multi-lane ADC sample beats into ADC_DWIDTH words with a one-cycle valid pulse.
// Optional ramp test source is enabled by defining ADC_PACKER_TEST_PATTERN_EN.
module adc_sample_packer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int LANES        = 4,
    parameter int ADC_DWIDTH   = 256
) (
    input  logic                          clk_i,
    input  logic                          reset_ni,
    input  logic                          capture_en_i,
    input  logic [LANES*SAMPLE_WIDTH-1:0] sample_data_i,
    input  logic                          sample_valid_i,
`ifdef ADC_PACKER_TEST_PATTERN_EN
    input  logic                          test_mode_i,
`endif
    output logic [ADC_DWIDTH-1:0]         adc_data_o,
    output logic                          adc_data_valid_o,
    output logic [31:0]                   word_count_o
);

    localparam int BW = SAMPLE_WIDTH * LANES;
    localparam int R  = ADC_DWIDTH / BW;
    localparam int PW = (R > 1) ? $clog2(R) : 1;

    logic [PW-1:0]         phase_r;
    logic [ADC_DWIDTH-1:0] asm_r;
    logic [ADC_DWIDTH-1:0] adc_data_r;
    logic                  valid_r;
    logic [31:0]           count_r;
    logic                  cap_d_r;

    logic                  cap_start_s;
    logic                  accept_s;
    logic                  last_phase_s;
    logic                  emit_s;
    logic [BW-1:0]         beat_s;
    logic [ADC_DWIDTH-1:0] word_s;

    assign cap_start_s  = capture_en_i && !cap_d_r;
    assign accept_s     = capture_en_i && sample_valid_i;
    assign last_phase_s = (phase_r == PW'(R - 1));
    assign emit_s       = accept_s && last_phase_s;

`ifdef ADC_PACKER_TEST_PATTERN_EN
    logic [SAMPLE_WIDTH-1:0] ramp_r;
    logic [SAMPLE_WIDTH-1:0] ramp_base_s;

    // A capture start restarts the ramp at zero for the beat accepted on that same edge.
    assign ramp_base_s = cap_start_s ? {SAMPLE_WIDTH{1'b0}} : ramp_r;

    // Beat source select: live samples or the ramp pattern.
    always_comb begin
        beat_s = sample_data_i;
        if (test_mode_i) begin
            for (int l = 0; l < LANES; l++) begin
                beat_s[l*SAMPLE_WIDTH +: SAMPLE_WIDTH] = ramp_base_s + SAMPLE_WIDTH'(l);
            end
        end else begin
            beat_s = sample_data_i;
        end
    end

    // Ramp state, advancing by LANES per accepted test-mode beat.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ramp_r <= {SAMPLE_WIDTH{1'b0}};
        end else if (accept_s && test_mode_i) begin
            ramp_r <= ramp_base_s + SAMPLE_WIDTH'(LANES);
        end else begin
            ramp_r <= ramp_base_s;
        end
    end
`else
    assign beat_s = sample_data_i;
`endif

    // Merge the incoming beat into its slot of the partially assembled word.
    always_comb begin
        word_s = asm_r;
        word_s[int'(phase_r)*BW +: BW] = beat_s;
    end

    // Phase, assembly and output word registers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cap_d_r    <= 1'b0;
            phase_r    <= {PW{1'b0}};
            asm_r      <= {ADC_DWIDTH{1'b0}};
            adc_data_r <= {ADC_DWIDTH{1'b0}};
            valid_r    <= 1'b0;
        end else begin
            cap_d_r <= capture_en_i;
            valid_r <= 1'b0;
            if (!capture_en_i) begin
                // Partial word is dropped; output word is held.
                phase_r <= {PW{1'b0}};
                asm_r   <= {ADC_DWIDTH{1'b0}};
            end else if (sample_valid_i) begin
                if (last_phase_s) begin
                    phase_r    <= {PW{1'b0}};
                    asm_r      <= {ADC_DWIDTH{1'b0}};
                    adc_data_r <= word_s;
                    valid_r    <= 1'b1;
                end else begin
                    phase_r <= phase_r + PW'(1);
                    asm_r   <= word_s;
                end
            end else begin
                phase_r <= phase_r;
            end
        end
    end

    // Saturating word counter, cleared on capture start.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_r <= 32'd0;
        end else if (cap_start_s) begin
            count_r <= emit_s ? 32'd1 : 32'd0;
        end else if (emit_s && (count_r != 32'hFFFF_FFFF)) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign adc_data_o       = adc_data_r;
    assign adc_data_valid_o = valid_r;
    assign word_count_o     = count_r;

endmodule
